// File: rtl/maquina_estados_param.sv
// Flow-control state machine for the FIFO bank: latches and validates the
// MF/VC/D threshold pairs, tracks activity with idle hysteresis and keeps sticky FIFO errors.
module maquina_estados_param #(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 2,
  parameter int IDLE_DLY  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [UMBRAL_W-1:0]  Umbral_MF_alto,
  input  logic [UMBRAL_W-1:0]  Umbral_MF_bajo,
  input  logic [UMBRAL_W-1:0]  Umbral_VC_alto,
  input  logic [UMBRAL_W-1:0]  Umbral_VC_bajo,
  input  logic [UMBRAL_W-1:0]  Umbral_D_alto,
  input  logic [UMBRAL_W-1:0]  Umbral_D_bajo,
  input  logic [NUM_FIFOS-1:0] FIFO_empties,
  input  logic [NUM_FIFOS-1:0] FIFO_errors,
  input  logic [NUM_FIFOS-1:0] error_mask,
  output logic [UMBRAL_W-1:0]  Umbral_MF_alto_interno,
  output logic [UMBRAL_W-1:0]  Umbral_MF_bajo_interno,
  output logic [UMBRAL_W-1:0]  Umbral_VC_alto_interno,
  output logic [UMBRAL_W-1:0]  Umbral_VC_bajo_interno,
  output logic [UMBRAL_W-1:0]  Umbral_D_alto_interno,
  output logic [UMBRAL_W-1:0]  Umbral_D_bajo_interno,
  output logic [2:0]           cfg_error_out,
  output logic                 error_out,
  output logic [NUM_FIFOS-1:0] errors_out,
  output logic                 active_out,
  output logic                 idle_out,
  output logic [2:0]           state_out
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam int               CNT_W     = $clog2(IDLE_DLY + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_DLY - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_DLY);

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [CNT_W-1:0]     idle_cnt;
  logic [NUM_FIFOS-1:0] err_vec;
  logic                 err_any;
  logic                 all_empty;

  assign err_vec   = FIFO_errors & ~error_mask;
  assign err_any   = |err_vec;
  assign all_empty = &FIFO_empties;

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_INIT;
      ST_INIT: begin
        if (err_any)   state_next = ST_ERROR;
        else if (init) state_next = ST_INIT;
        else           state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (err_any)         state_next = ST_ERROR;
        else if (init)       state_next = ST_INIT;
        else if (!all_empty) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err_any)                               state_next = ST_ERROR;
        else if (init)                             state_next = ST_INIT;
        else if (all_empty && idle_cnt == IDLE_LAST) state_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (init) state_next = ST_INIT;
      end
      default: state_next = ST_RESET;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RESET;
    else        state <= state_next;
  end

  // Counts consecutive all-empty edges in ACTIVE; saturates rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (state == ST_ACTIVE && all_empty) begin
      if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + CNT_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  // Each pair is validated independently; a rejected pair keeps its previous values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Umbral_MF_alto_interno <= '0;
      Umbral_MF_bajo_interno <= '0;
      Umbral_VC_alto_interno <= '0;
      Umbral_VC_bajo_interno <= '0;
      Umbral_D_alto_interno  <= '0;
      Umbral_D_bajo_interno  <= '0;
      cfg_error_out          <= '0;
    end else if (state == ST_INIT) begin
      if (Umbral_MF_bajo <= Umbral_MF_alto) begin
        Umbral_MF_alto_interno <= Umbral_MF_alto;
        Umbral_MF_bajo_interno <= Umbral_MF_bajo;
        cfg_error_out[0]       <= 1'b0;
      end else begin
        cfg_error_out[0]       <= 1'b1;
      end
      if (Umbral_VC_bajo <= Umbral_VC_alto) begin
        Umbral_VC_alto_interno <= Umbral_VC_alto;
        Umbral_VC_bajo_interno <= Umbral_VC_bajo;
        cfg_error_out[1]       <= 1'b0;
      end else begin
        cfg_error_out[1]       <= 1'b1;
      end
      if (Umbral_D_bajo <= Umbral_D_alto) begin
        Umbral_D_alto_interno <= Umbral_D_alto;
        Umbral_D_bajo_interno <= Umbral_D_bajo;
        cfg_error_out[2]      <= 1'b0;
      end else begin
        cfg_error_out[2]      <= 1'b1;
      end
    end
  end

  // Sticky error capture: load on entry to ERROR, accumulate while staying, clear on entry to INIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errors_out <= '0;
    end else if (state_next == ST_ERROR) begin
      if (state == ST_ERROR) errors_out <= errors_out | err_vec;
      else                   errors_out <= err_vec;
    end else if (state_next == ST_INIT && state != ST_INIT) begin
      errors_out <= '0;
    end
  end

  assign state_out  = state;
  assign error_out  = (state == ST_ERROR);
  assign active_out = (state == ST_ACTIVE);
  assign idle_out   = (state == ST_IDLE);

endmodule

// File: tb/tb_maquina_estados_param.sv
// Self-checking bench for maquina_estados_param: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_maquina_estados_param;

  localparam int NF = 5;
  localparam int UW = 2;
  localparam int ID = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [UW-1:0] thr_in  [6];
  logic [UW-1:0] thr_out [6];
  logic [NF-1:0] empties, errs, mask;
  logic [2:0]    cfg_error_out, state_out;
  logic          error_out, active_out, idle_out;
  logic [NF-1:0] errors_out;

  int total = 0;
  int bad   = 0;

  // Reference model (state as plain integer 0..4, run = consecutive empty edges in ACTIVE)
  int            m_state;
  int            m_run;
  logic [UW-1:0] m_thr [6];
  logic [2:0]    m_cfg;
  logic [NF-1:0] m_err;

  always #5 clk = ~clk;

  maquina_estados_param #(.NUM_FIFOS(NF), .UMBRAL_W(UW), .IDLE_DLY(ID)) dut (
    .clk(clk), .reset(reset), .init(init),
    .Umbral_MF_alto(thr_in[0]), .Umbral_MF_bajo(thr_in[1]),
    .Umbral_VC_alto(thr_in[2]), .Umbral_VC_bajo(thr_in[3]),
    .Umbral_D_alto(thr_in[4]),  .Umbral_D_bajo(thr_in[5]),
    .FIFO_empties(empties), .FIFO_errors(errs), .error_mask(mask),
    .Umbral_MF_alto_interno(thr_out[0]), .Umbral_MF_bajo_interno(thr_out[1]),
    .Umbral_VC_alto_interno(thr_out[2]), .Umbral_VC_bajo_interno(thr_out[3]),
    .Umbral_D_alto_interno(thr_out[4]),  .Umbral_D_bajo_interno(thr_out[5]),
    .cfg_error_out(cfg_error_out), .error_out(error_out), .errors_out(errors_out),
    .active_out(active_out), .idle_out(idle_out), .state_out(state_out)
  );

  task automatic model_reset();
    m_state = 0;
    m_run   = 0;
    for (int i = 0; i < 6; i++) m_thr[i] = '0;
    m_cfg = '0;
    m_err = '0;
  endtask

  task automatic model_step();
    logic [NF-1:0] uerr;
    bit            any_err, all_e;
    int            nxt;
    uerr    = errs & ~mask;
    any_err = (uerr != '0);
    all_e   = (empties == '1);
    nxt     = m_state;
    if (m_state == 0)                     nxt = 1;
    else if (m_state == 4)                nxt = init ? 1 : 4;
    else if (any_err)                     nxt = 4;
    else if (init)                        nxt = 1;
    else if (m_state == 1)                nxt = 2;
    else if (m_state == 2)                nxt = all_e ? 2 : 3;
    else if (all_e && m_run + 1 >= ID)    nxt = 2;
    if (m_state == 3 && all_e) m_run = m_run + 1;
    else                       m_run = 0;
    if (m_state == 1) begin
      for (int p = 0; p < 3; p++) begin
        if (thr_in[2*p+1] <= thr_in[2*p]) begin
          m_thr[2*p]   = thr_in[2*p];
          m_thr[2*p+1] = thr_in[2*p+1];
          m_cfg[p]     = 1'b0;
        end else begin
          m_cfg[p] = 1'b1;
        end
      end
    end
    if (nxt == 4 && m_state != 4) m_err = uerr;
    else if (nxt == 4)            m_err = m_err | uerr;
    else if (nxt == 1 && m_state != 1) m_err = '0;
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_thr(input logic [UW-1:0] mfa, mfb, vca, vcb, da, db);
    thr_in[0] = mfa; thr_in[1] = mfb; thr_in[2] = vca;
    thr_in[3] = vcb; thr_in[4] = da;  thr_in[5] = db;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; empties = '1; errs = '0; mask = '0;
    set_thr(2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b11);
    model_reset();
    #2;
    total++;
    if (state_out !== 3'd0 || error_out !== 1'b0 || active_out !== 1'b0 || idle_out !== 1'b0 ||
        errors_out !== '0 || cfg_error_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs: state=%0d err=%b act=%b idle=%b errs=%b cfg=%b, want all 0",
               state_out, error_out, active_out, idle_out, errors_out, cfg_error_out);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (thr_out[i] !== '0) begin
        bad++;
        $display("FAIL reset_thr%0d: got %b want 00", i, thr_out[i]);
      end
    end
    reset = 1'b1;
    tick();
    total++;
    if (state_out !== 3'd1) begin
      bad++;
      $display("FAIL release_init: state=%0d want 1", state_out);
    end
    tick();
    total++;
    if (state_out !== 3'd2 || idle_out !== 1'b1 || cfg_error_out !== 3'b000) begin
      bad++;
      $display("FAIL release_idle: state=%0d idle=%b cfg=%b want 2/1/000", state_out, idle_out, cfg_error_out);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (thr_out[i] !== thr_in[i]) begin
        bad++;
        $display("FAIL first_load_thr%0d: got %b want %b", i, thr_out[i], thr_in[i]);
      end
    end
  endtask

  task automatic test_invalid_pair();
    init = 1'b1;
    tick();
    total++;
    if (state_out !== 3'd1) begin
      bad++;
      $display("FAIL inv_enter_init: state=%0d want 1", state_out);
    end
    init = 1'b0;
    set_thr(2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00);
    tick();
    total++;
    if (state_out !== 3'd2 || cfg_error_out !== 3'b001) begin
      bad++;
      $display("FAIL inv_cfg: state=%0d cfg=%b want 2/001", state_out, cfg_error_out);
    end
    total++;
    if (thr_out[0] !== 2'b01 || thr_out[1] !== 2'b00) begin
      bad++;
      $display("FAIL inv_mf_kept: alto=%b bajo=%b want 01/00", thr_out[0], thr_out[1]);
    end
    total++;
    if (thr_out[2] !== 2'b11 || thr_out[3] !== 2'b10 || thr_out[4] !== 2'b10 || thr_out[5] !== 2'b00) begin
      bad++;
      $display("FAIL inv_vc_d_load: vc=%b/%b d=%b/%b want 11/10 10/00",
               thr_out[2], thr_out[3], thr_out[4], thr_out[5]);
    end
    init = 1'b1;
    tick();
    init = 1'b0;
    set_thr(2'b11, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00);
    tick();
    total++;
    if (cfg_error_out !== 3'b000 || thr_out[0] !== 2'b11 || thr_out[1] !== 2'b01) begin
      bad++;
      $display("FAIL inv_recover: cfg=%b mf=%b/%b want 000 11/01", cfg_error_out, thr_out[0], thr_out[1]);
    end
  endtask

  task automatic test_hysteresis();
    logic [NF-1:0] pat [5];
    logic [2:0]    exp_state [5];
    pat = '{5'b11011, 5'b11111, 5'b11011, 5'b11111, 5'b11111};
    exp_state = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2};
    for (int i = 0; i < 5; i++) begin
      empties = pat[i];
      tick();
      total++;
      if (state_out !== exp_state[i] || active_out !== (exp_state[i] == 3'd3) ||
          idle_out !== (exp_state[i] == 3'd2)) begin
        bad++;
        $display("FAIL hyst_step%0d: state=%0d act=%b idle=%b want state %0d",
                 i, state_out, active_out, idle_out, exp_state[i]);
      end
    end
  endtask

  task automatic test_errors();
    mask = 5'b00010; errs = 5'b00010;
    tick();
    total++;
    if (state_out !== 3'd2 || errors_out !== 5'b00000) begin
      bad++;
      $display("FAIL err_masked: state=%0d errs=%b want 2/00000", state_out, errors_out);
    end
    errs = 5'b00100;
    tick();
    total++;
    if (error_out !== 1'b1 || state_out !== 3'd4 || errors_out !== 5'b00100) begin
      bad++;
      $display("FAIL err_capture: err=%b state=%0d errs=%b want 1/4/00100", error_out, state_out, errors_out);
    end
    errs = 5'b01000;
    tick();
    total++;
    if (errors_out !== 5'b01100 || error_out !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: errs=%b err=%b want 01100/1", errors_out, error_out);
    end
    errs = '0; init = 1'b1;
    tick();
    total++;
    if (state_out !== 3'd1 || errors_out !== 5'b00000) begin
      bad++;
      $display("FAIL err_clear: state=%0d errs=%b want 1/00000", state_out, errors_out);
    end
    init = 1'b0; mask = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    init = 1'b1; errs = 5'b00001;
    tick();
    total++;
    if (state_out !== 3'd4 || errors_out !== 5'b00001) begin
      bad++;
      $display("FAIL simul_error_wins: state=%0d errs=%b want 4/00001", state_out, errors_out);
    end
    tick();
    total++;
    if (state_out !== 3'd1 || errors_out !== 5'b00000) begin
      bad++;
      $display("FAIL simul_init_leaves: state=%0d errs=%b want 1/00000", state_out, errors_out);
    end
    tick();
    total++;
    if (state_out !== 3'd4) begin
      bad++;
      $display("FAIL simul_reenter: state=%0d want 4", state_out);
    end
    errs = '0;
    tick();
    init = 1'b0;
    tick();
    total++;
    if (state_out !== 3'd2) begin
      bad++;
      $display("FAIL simul_settle: state=%0d want 2", state_out);
    end
  endtask

  task automatic test_async_reset();
    empties = 5'b11011;
    tick();
    total++;
    if (state_out !== 3'd3) begin
      bad++;
      $display("FAIL ar_active: state=%0d want 3", state_out);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (state_out !== 3'd0 || active_out !== 1'b0 || cfg_error_out !== '0 || errors_out !== '0) begin
      bad++;
      $display("FAIL ar_clear: state=%0d act=%b cfg=%b errs=%b want all 0",
               state_out, active_out, cfg_error_out, errors_out);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (thr_out[i] !== '0) begin
        bad++;
        $display("FAIL ar_thr%0d: got %b want 00", i, thr_out[i]);
      end
    end
    empties = '1;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (state_out !== 3'd2) begin
      bad++;
      $display("FAIL ar_recover: state=%0d want 2", state_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      init    = ($urandom_range(0, 9) == 0);
      errs    = ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0;
      mask    = NF'($urandom);
      empties = ($urandom_range(0, 2) == 0) ? NF'($urandom) : '1;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 6; i++) thr_in[i] = UW'($urandom);
      tick();
      total++;
      if (state_out !== 3'(m_state) || error_out !== (m_state == 4) ||
          active_out !== (m_state == 3) || idle_out !== (m_state == 2)) begin
        bad++;
        $display("FAIL rnd_state c=%0d: state=%0d e=%b a=%b i=%b want %0d", c,
                 state_out, error_out, active_out, idle_out, m_state);
      end
      total++;
      if (errors_out !== m_err || cfg_error_out !== m_cfg) begin
        bad++;
        $display("FAIL rnd_vec c=%0d: errs=%b cfg=%b want %b/%b", c, errors_out, cfg_error_out, m_err, m_cfg);
      end
      for (int i = 0; i < 6; i++) begin
        total++;
        if (thr_out[i] !== m_thr[i]) begin
          bad++;
          $display("FAIL rnd_thr%0d c=%0d: got %b want %b", i, c, thr_out[i], m_thr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_invalid_pair();
    test_hysteresis();
    test_errors();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
